// File: rtl/bram_clip_loader.sv
// Purpose : bursts NUM_CH x CLIP_LEN packed samples out of PS-written BRAM into a
//           shadow bank, applies a signed volume shift, then swaps banks atomically.
// Latency : done_irq rises TOTAL + BRAM_LATENCY + 1 cycles after the edge that starts a load;
//           rd_data is registered, so it follows rd_ch/rd_idx by one cycle.
// Backpressure: none on BRAM (fixed latency). A start seen while busy is queued,
//           one request deep; any further starts are absorbed.
//
// Ports:
//   clk, rst              system clock, asynchronous active-high reset
//   start                 load request, level-sampled
//   base_addr, volume     byte address of word 0 and right-shift amount, latched at launch
//   bram_*                read-only BRAM master port (bram_clk mirrors clk)
//   busy, done_irq        not-idle flag, one-cycle pulse on each bank swap
//   active_bank           bank currently served on the read port
//   rd_ch, rd_idx, rd_data  synth-engine read port into the active bank
module bram_clip_loader #(
    parameter int SAMPLE_BITS  = 16,
    parameter int CLIP_LEN     = 64,
    parameter int NUM_CH       = 2,
    parameter int PACK         = 2,
    parameter int BRAM_LATENCY = 2,
    parameter int VOLUME_BITS  = 4,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int IDX_W = (CLIP_LEN > 1) ? $clog2(CLIP_LEN) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [31:0]            base_addr,
    input  logic [VOLUME_BITS-1:0] volume,
    output logic                   bram_clk,
    output logic [31:0]            bram_addr,
    output logic                   bram_en,
    output logic [3:0]             bram_we,
    output logic [31:0]            bram_din,
    input  logic [31:0]            bram_dout,
    output logic                   bram_rst,
    output logic                   busy,
    output logic                   done_irq,
    output logic                   active_bank,
    input  logic [CH_W-1:0]        rd_ch,
    input  logic [IDX_W-1:0]       rd_idx,
    output logic [SAMPLE_BITS-1:0] rd_data
);

    localparam int WPC   = CLIP_LEN / PACK;
    localparam int TOTAL = NUM_CH * WPC;
    localparam int NSAMP = NUM_CH * CLIP_LEN;
    localparam int W_W   = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int S_W   = (NSAMP > 1) ? $clog2(NSAMP) : 1;
    localparam int L_W   = (BRAM_LATENCY > 1) ? $clog2(BRAM_LATENCY) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_SWAP  = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic                     pending_q, pending_d;
    logic                     loaded_q, loaded_d;
    logic                     bank_q, bank_d;
    logic [31:0]              addr_q, addr_d;
    logic                     en_q, en_d;
    logic [VOLUME_BITS-1:0]   vol_q, vol_d;
    logic [W_W-1:0]           wcnt_q, wcnt_d;
    logic [L_W-1:0]           dcnt_q, dcnt_d;
    logic [BRAM_LATENCY-1:0]  pipe_vld_q, pipe_vld_d;
    logic [W_W-1:0]           pipe_w_q [BRAM_LATENCY];
    logic [W_W-1:0]           pipe_w_d [BRAM_LATENCY];
    logic                     bram_rst_q, bram_rst_d;
    logic                     done_q, done_d;
    logic [SAMPLE_BITS-1:0]   rd_data_q, rd_data_d;

    logic                     launch;
    logic                     cap_vld;
    logic [W_W-1:0]           cap_w;
    logic                     shadow;
    logic [S_W-1:0]           wr_sidx [PACK];
    logic signed [SAMPLE_BITS-1:0] cap_fld [PACK];
    logic [SAMPLE_BITS-1:0]   wr_val [PACK];
    logic [S_W-1:0]           rd_sidx;
    logic                     unused_dout;

    // Two banks of samples, flat-indexed as {ch, idx}.
    logic [SAMPLE_BITS-1:0]   bank_mem [2][NSAMP];

    // Read-port bits that a narrow PACK=1 build never looks at.
    assign unused_dout = ^bram_dout;

    // A new load starts from IDLE on a request, or straight out of SWAP when one is queued.
    assign launch = ((state_q == ST_IDLE) && (start || pending_q))
                 || ((state_q == ST_SWAP) && pending_q);

    assign shadow  = ~bank_q;
    assign cap_vld = pipe_vld_q[BRAM_LATENCY-1];
    assign cap_w   = pipe_w_q[BRAM_LATENCY-1];
    assign rd_sidx = S_W'({rd_ch, rd_idx});

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pending_q  <= 1'b0;
            loaded_q   <= 1'b0;
            bank_q     <= 1'b0;
            addr_q     <= '0;
            en_q       <= 1'b0;
            vol_q      <= '0;
            wcnt_q     <= '0;
            dcnt_q     <= '0;
            pipe_vld_q <= '0;
            for (int i = 0; i < BRAM_LATENCY; i++) pipe_w_q[i] <= '0;
            bram_rst_q <= 1'b1;
            done_q     <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            loaded_q   <= loaded_d;
            bank_q     <= bank_d;
            addr_q     <= addr_d;
            en_q       <= en_d;
            vol_q      <= vol_d;
            wcnt_q     <= wcnt_d;
            dcnt_q     <= dcnt_d;
            pipe_vld_q <= pipe_vld_d;
            for (int i = 0; i < BRAM_LATENCY; i++) pipe_w_q[i] <= pipe_w_d[i];
            bram_rst_q <= bram_rst_d;
            done_q     <= done_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Shadow-bank writes; contents need no reset because loaded gates the read port.
    always_ff @(posedge clk) begin
        if (cap_vld) begin
            for (int j = 0; j < PACK; j++) bank_mem[shadow][wr_sidx[j]] <= wr_val[j];
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start || pending_q) state_d = ST_ISSUE;
            ST_ISSUE: if (wcnt_q == W_W'(TOTAL - 1)) state_d = ST_DRAIN;
            ST_DRAIN: if (dcnt_q == L_W'(BRAM_LATENCY - 1)) state_d = ST_SWAP;
            ST_SWAP:  state_d = pending_q ? ST_ISSUE : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------- outputs / datapath ----------------
    always_comb begin
        pending_d  = pending_q;
        loaded_d   = loaded_q;
        bank_d     = bank_q;
        addr_d     = addr_q;
        en_d       = en_q;
        vol_d      = vol_q;
        wcnt_d     = wcnt_q;
        dcnt_d     = dcnt_q;
        bram_rst_d = 1'b0;
        done_d     = 1'b0;

        // Queue a single request while busy; consuming it at launch clears it.
        if (launch) begin
            pending_d = 1'b0;
        end else if (start && (state_q != ST_IDLE)) begin
            pending_d = 1'b1;
        end

        if (launch) begin
            addr_d = base_addr;
            en_d   = 1'b1;
            vol_d  = volume;
            wcnt_d = '0;
        end else if (state_q == ST_ISSUE) begin
            addr_d = addr_q + 32'd4;
            wcnt_d = wcnt_q + W_W'(1);
            if (wcnt_q == W_W'(TOTAL - 1)) begin
                en_d   = 1'b0;
                dcnt_d = '0;
            end
        end else if (state_q == ST_DRAIN) begin
            dcnt_d = dcnt_q + L_W'(1);
        end

        if (state_q == ST_SWAP) begin
            bank_d   = ~bank_q;
            loaded_d = 1'b1;
            done_d   = 1'b1;
        end

        // Token pipe: one entry per issued address, aligned with bram_dout on exit.
        pipe_vld_d[0] = (state_q == ST_ISSUE);
        pipe_w_d[0]   = wcnt_q;
        for (int i = 1; i < BRAM_LATENCY; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_w_d[i]   = pipe_w_q[i-1];
        end

        // Unpack, sign-extend and attenuate; a shift >= SAMPLE_BITS leaves only sign bits.
        for (int j = 0; j < PACK; j++) begin
            cap_fld[j] = $signed(bram_dout[j*16 +: SAMPLE_BITS]);
            wr_val[j]  = SAMPLE_BITS'(cap_fld[j] >>> vol_q);
            wr_sidx[j] = S_W'(int'(cap_w) * PACK + j);
        end

        // Look up with the next-cycle bank so the swap is visible immediately after SWAP.
        rd_data_d = loaded_d ? bank_mem[bank_d][rd_sidx] : '0;
    end

    assign bram_clk    = clk;
    assign bram_addr   = addr_q;
    assign bram_en     = en_q;
    assign bram_we     = 4'b0000;
    assign bram_din    = 32'd0;
    assign bram_rst    = bram_rst_q;
    assign busy        = (state_q != ST_IDLE);
    assign done_irq    = done_q;
    assign active_bank = bank_q;
    assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_bram_clip_loader.sv
`timescale 1ns/1ps
// Bench for bram_clip_loader: a default build and a PACK=1, NUM_CH=4 build, each fed by a
// behavioural fixed-latency BRAM. Expected samples and done_irq cycles are queued when a
// load is launched and consumed as the DUT produces them.
module tb_bram_clip_loader;

    localparam int SB    = 16;
    localparam int CL    = 64;
    localparam int NC    = 2;
    localparam int PK    = 2;
    localparam int LAT   = 2;
    localparam int VB    = 4;
    localparam int WPC   = CL / PK;
    localparam int TOTAL = NC * WPC;
    localparam int NC_B    = 4;
    localparam int TOTAL_B = NC_B * CL;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // ---------------- DUT A: default build ----------------
    logic        start_a = 1'b0;
    logic [31:0] base_a = '0;
    logic [VB-1:0] vol_a = '0;
    logic        bram_clk_a, bram_en_a, bram_rst_a, busy_a, done_irq_a, active_bank_a;
    logic [31:0] bram_addr_a, bram_din_a, bram_dout_a;
    logic [3:0]  bram_we_a;
    logic [0:0]  rd_ch_a = '0;
    logic [5:0]  rd_idx_a = '0;
    logic [SB-1:0] rd_data_a;

    bram_clip_loader u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .base_addr(base_a), .volume(vol_a),
        .bram_clk(bram_clk_a), .bram_addr(bram_addr_a), .bram_en(bram_en_a),
        .bram_we(bram_we_a), .bram_din(bram_din_a), .bram_dout(bram_dout_a),
        .bram_rst(bram_rst_a), .busy(busy_a), .done_irq(done_irq_a),
        .active_bank(active_bank_a), .rd_ch(rd_ch_a), .rd_idx(rd_idx_a), .rd_data(rd_data_a)
    );

    logic [31:0] mem_a [1024];
    logic [31:0] pipe_a [LAT];
    always @(posedge clk) begin
        if (bram_en_a) pipe_a[0] <= mem_a[bram_addr_a[11:2]];
        for (int i = 1; i < LAT; i++) pipe_a[i] <= pipe_a[i-1];
    end
    assign bram_dout_a = pipe_a[LAT-1];

    logic [31:0] addr_log[$];
    always @(posedge clk) if (bram_en_a) addr_log.push_back(bram_addr_a);

    // ---------------- DUT B: PACK=1, NUM_CH=4 ----------------
    logic        start_b = 1'b0;
    logic [31:0] base_b = '0;
    logic [VB-1:0] vol_b = '0;
    logic        bram_clk_b, bram_en_b, bram_rst_b, busy_b, done_irq_b, active_bank_b;
    logic [31:0] bram_addr_b, bram_din_b, bram_dout_b;
    logic [3:0]  bram_we_b;
    logic [1:0]  rd_ch_b = '0;
    logic [5:0]  rd_idx_b = '0;
    logic [SB-1:0] rd_data_b;

    bram_clip_loader #(.SAMPLE_BITS(SB), .CLIP_LEN(CL), .NUM_CH(NC_B), .PACK(1),
                       .BRAM_LATENCY(LAT), .VOLUME_BITS(VB)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .base_addr(base_b), .volume(vol_b),
        .bram_clk(bram_clk_b), .bram_addr(bram_addr_b), .bram_en(bram_en_b),
        .bram_we(bram_we_b), .bram_din(bram_din_b), .bram_dout(bram_dout_b),
        .bram_rst(bram_rst_b), .busy(busy_b), .done_irq(done_irq_b),
        .active_bank(active_bank_b), .rd_ch(rd_ch_b), .rd_idx(rd_idx_b), .rd_data(rd_data_b)
    );

    logic [31:0] mem_b [1024];
    logic [31:0] pipe_b [LAT];
    int          addr_cnt_b = 0;
    logic [31:0] addr_last_b = '0;
    always @(posedge clk) begin
        if (bram_en_b) begin
            pipe_b[0]   <= mem_b[bram_addr_b[11:2]];
            addr_cnt_b  <= addr_cnt_b + 1;
            addr_last_b <= bram_addr_b;
        end
        for (int i = 1; i < LAT; i++) pipe_b[i] <= pipe_b[i-1];
    end
    assign bram_dout_b = pipe_b[LAT-1];

    // ---------------- scoreboards ----------------
    int unsigned exp_done[$];
    logic [31:0] sb_q[$];
    int          done_cnt = 0;
    logic        exp_bank = 1'b0;

    always @(negedge clk) begin
        if (!rst && done_irq_a) begin
            done_cnt++;
            if (exp_done.size() > 0) chk("done_cycle", cyc, exp_done.pop_front());
            else chk("done_unexpected", cyc, 32'hFFFF_FFFF);
        end
    end

    // Independent sample model: word layout, sign extension and arithmetic shift.
    function automatic logic [15:0] model_a(input int ch, input int idx, input int base, input int vol);
        logic [31:0] word;
        logic signed [15:0] s;
        word = mem_a[(base / 4 + ch * WPC + idx / PK) % 1024];
        s = (idx % PK == 1) ? word[31:16] : word[15:0];
        return 16'(s >>> vol);
    endfunction

    function automatic logic [15:0] model_b(input int ch, input int idx, input int base, input int vol);
        logic [31:0] word;
        logic signed [15:0] s;
        word = mem_b[(base / 4 + ch * CL + idx) % 1024];
        s = word[15:0];
        return 16'(s >>> vol);
    endfunction

    task automatic push_all_a(input int base, input int vol);
        for (int ch = 0; ch < NC; ch++)
            for (int i = 0; i < CL; i++) sb_q.push_back(32'(model_a(ch, i, base, vol)));
    endtask

    task automatic kick_a(input logic [31:0] base, input int vol, output int unsigned s);
        @(negedge clk);
        base_a  = base;
        vol_a   = VB'(vol);
        start_a = 1'b1;
        s = cyc + 1;
        exp_done.push_back(s + TOTAL + LAT + 1);
        exp_bank = ~exp_bank;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!done_irq_a && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) chk("done_timeout", 32'(done_irq_a), 32'd1);
    endtask

    task automatic wait_cyc(input int unsigned target);
        do @(negedge clk); while (cyc < target);
    endtask

    task automatic read_a(input int ch, input int idx, output logic [15:0] v);
        @(negedge clk);
        rd_ch_a  = 1'(ch);
        rd_idx_a = 6'(idx);
        @(negedge clk);
        v = rd_data_a;
    endtask

    task automatic read_b(input int ch, input int idx, output logic [15:0] v);
        @(negedge clk);
        rd_ch_b  = 2'(ch);
        rd_idx_b = 6'(idx);
        @(negedge clk);
        v = rd_data_b;
    endtask

    task automatic sweep_a(input string tag);
        logic [15:0] v;
        for (int ch = 0; ch < NC; ch++) begin
            for (int i = 0; i < CL; i++) begin
                read_a(ch, i, v);
                if (sb_q.size() == 0) chk("sb_empty", 32'(v), 32'hFFFF_FFFF);
                else chk(tag, 32'(v), sb_q.pop_front());
            end
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned s;
        int          n;
        int          cnt0;
        logic [15:0] v;
        logic [15:0] old_v;
        logic [15:0] new_v;

        for (int w = 0; w < 1024; w++) begin
            mem_a[w] = '0;
            mem_b[w] = '0;
        end

        // ---- reset state ----
        repeat (3) @(negedge clk);
        chk("rst_bram_rst", 32'(bram_rst_a), 32'd1);
        chk("rst_rd_data", 32'(rd_data_a), 32'd0);
        chk("rst_active_bank", 32'(active_bank_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_bram_en", 32'(bram_en_a), 32'd0);
        chk("rst_done_irq", 32'(done_irq_a), 32'd0);
        chk("rst_bram_we", 32'(bram_we_a), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("bram_rst_release", 32'(bram_rst_a), 32'd0);
        repeat (3) @(negedge clk);
        chk("idle_bram_en", 32'(bram_en_a), 32'd0);
        chk("idle_busy", 32'(busy_a), 32'd0);

        // ---- default preload, base 0x100, volume 0 ----
        for (int w = 0; w < TOTAL; w++) mem_a[64 + w] = {16'(2 * w + 1), 16'(2 * w)};
        addr_log.delete();
        push_all_a(32'h100, 0);
        kick_a(32'h100, 0, s);
        chk("busy_loading", 32'(busy_a), 32'd1);
        wait_done_a(200);
        chk("addr_count", 32'(addr_log.size()), 32'(TOTAL));
        for (int i = 0; i < addr_log.size() && i < TOTAL; i++)
            chk("addr_seq", addr_log[i], 32'h100 + 32'(4 * i));
        chk("active_bank_1", 32'(active_bank_a), 32'(exp_bank));
        read_a(1, 5, v);
        chk("ch1_idx5", 32'(v), 32'd69);
        sweep_a("preload_sample");

        // ---- volume shift with sign preservation ----
        mem_a[128] = 32'h8000_7FF8;
        kick_a(32'h200, 3, s);
        sb_q.push_back(32'h0FFF);
        sb_q.push_back(32'hF000);
        wait_done_a(200);
        read_a(0, 0, v);
        chk("vol3_idx0", 32'(v), sb_q.pop_front());
        read_a(0, 1, v);
        chk("vol3_idx1", 32'(v), sb_q.pop_front());
        kick_a(32'h200, 15, s);
        sb_q.push_back(32'hFFFF);
        sb_q.push_back(32'h0000);
        wait_done_a(200);
        read_a(0, 1, v);
        chk("vol15_idx1", 32'(v), sb_q.pop_front());
        read_a(0, 0, v);
        chk("vol15_idx0", 32'(v), sb_q.pop_front());
        chk("bank_after_vol", 32'(active_bank_a), 32'(exp_bank));

        // ---- two starts while busy: one queued load, the other absorbed ----
        cnt0 = done_cnt;
        kick_a(32'h100, 1, s);
        wait_cyc(s + 9);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        exp_done.push_back(s + 2 * (TOTAL + LAT + 1));
        exp_bank = ~exp_bank;
        wait_cyc(s + 29);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_cyc(s + TOTAL + LAT + 1);
        chk("requeue_en", 32'(bram_en_a), 32'd1);
        chk("requeue_addr", bram_addr_a, 32'h100);
        wait_done_a(200);
        repeat (20) @(negedge clk);
        chk("pending_done_count", 32'(done_cnt - cnt0), 32'd2);
        chk("pending_bank", 32'(active_bank_a), 32'(exp_bank));
        chk("pending_idle", 32'(busy_a), 32'd0);

        // ---- read port holds old data until the swap ----
        for (int w = 0; w < TOTAL; w++) mem_a[384 + w] = 32'h5555_1111;
        kick_a(32'h600, 0, s);
        wait_done_a(200);
        old_v = 16'h1111;
        new_v = 16'h2222;
        mem_a[384] = 32'h5555_2222;
        @(negedge clk);
        rd_ch_a  = 1'b0;
        rd_idx_a = 6'd0;
        kick_a(32'h600, 0, s);
        n = 0;
        while (!done_irq_a && n < 200) begin
            chk("rd_hold_old", 32'(rd_data_a), 32'(old_v));
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("swap_timeout", 32'(done_irq_a), 32'd1);
        chk("rd_at_swap", 32'((rd_data_a == old_v) || (rd_data_a == new_v)), 32'd1);
        @(negedge clk);
        chk("rd_new_after_swap", 32'(rd_data_a), 32'(new_v));

        // ---- reset in the middle of ISSUE, then a clean reload ----
        for (int w = 0; w < TOTAL; w++) mem_a[256 + w] = {16'(w * 5 + 3), 16'(16'hA000 + 16'(w))};
        kick_a(32'h400, 2, s);
        n = 0;
        while (bram_addr_a != 32'h400 + 32'd80 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("word20_timeout", bram_addr_a, 32'h450);
        rst = 1'b1;
        exp_done.delete();
        exp_bank = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(busy_a), 32'd0);
        chk("midrst_bank", 32'(active_bank_a), 32'd0);
        chk("midrst_rd", 32'(rd_data_a), 32'd0);
        chk("midrst_en", 32'(bram_en_a), 32'd0);
        chk("midrst_bram_rst", 32'(bram_rst_a), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        read_a(1, 7, v);
        chk("midrst_unloaded", 32'(v), 32'd0);
        push_all_a(32'h400, 2);
        kick_a(32'h400, 2, s);
        n = 0;
        while (!done_irq_a && n < 200) begin
            chk("reload_rd_zero", 32'(rd_data_a), 32'd0);
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("reload_timeout", 32'(done_irq_a), 32'd1);
        chk("reload_bank", 32'(active_bank_a), 32'(exp_bank));
        sweep_a("reload_sample");

        // ---- PACK=1, NUM_CH=4 build ----
        for (int w = 0; w < TOTAL_B; w++) mem_b[w] = {16'hDEAD, 16'(w * 7) ^ 16'h8001};
        for (int ch = 0; ch < NC_B; ch++)
            for (int i = 0; i < CL; i++) sb_q.push_back(32'(model_b(ch, i, 0, 1)));
        @(negedge clk);
        base_b  = 32'h0;
        vol_b   = VB'(1);
        start_b = 1'b1;
        s = cyc + 1;
        @(negedge clk);
        start_b = 1'b0;
        n = 0;
        while (!done_irq_b && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("b_done_cycle", cyc, s + TOTAL_B + LAT + 1);
        chk("b_addr_count", 32'(addr_cnt_b), 32'(TOTAL_B));
        chk("b_addr_last", addr_last_b, 32'(4 * (TOTAL_B - 1)));
        chk("b_bank", 32'(active_bank_b), 32'd1);
        for (int ch = 0; ch < NC_B; ch++) begin
            for (int i = 0; i < CL; i++) begin
                read_b(ch, i, v);
                if (sb_q.size() == 0) chk("sb_empty_b", 32'(v), 32'hFFFF_FFFF);
                else chk("b_sample", 32'(v), sb_q.pop_front());
            end
        end

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
